// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush controller: sequences the iterative mult/div unit and merges
// branch flush, mult/div stall and load-use stall. Optional STALL_STATS_EN adds event counters.
module pipeline_stall_ctrl #(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned CNT_W      = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ID_EX_MemRead,
    input  logic [4:0] ID_EX_Rt,
    input  logic [4:0] IF_ID_Rs,
    input  logic [4:0] IF_ID_Rt,
    input  logic       ID_MdUse,
    input  logic       EX_MdStart,
    input  logic       EX_MdIsDiv,
    input  logic       Branch_Taken,
    output logic       PCWrite,
    output logic       IF_ID_Write,
    output logic       IF_ID_Flush,
    output logic       ID_EX_Flush,
    output logic       Md_Busy,
    output logic       Md_Done
`ifdef STALL_STATS_EN
    ,
    output logic [31:0] Stat_LdStall,
    output logic [31:0] Stat_MdStall,
    output logic [31:0] Stat_Flush
`endif
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [CNT_W-1:0] MulLoad = CNT_W'(MUL_CYCLES - 2);
    localparam logic [CNT_W-1:0] DivLoad = CNT_W'(DIV_CYCLES - 2);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] start_cnt;

    assign start_cnt = EX_MdIsDiv ? DivLoad : MulLoad;

    // A start in DONE reloads directly so back-to-back operations see no idle gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (EX_MdStart) begin
                        cnt_q   <= start_cnt;
                        state_q <= (start_cnt == '0) ? StDone : StRun;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= StDone;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign Md_Busy = (state_q != StIdle);
    assign Md_Done = (state_q == StDone);

    logic md_stall;
    logic ld_stall;

    assign md_stall = Md_Busy && ID_MdUse;
    assign ld_stall = ID_EX_MemRead && (ID_EX_Rt != 5'd0) &&
                      ((ID_EX_Rt == IF_ID_Rs) || (ID_EX_Rt == IF_ID_Rt));

    always_comb begin
        PCWrite     = 1'b1;
        IF_ID_Write = 1'b1;
        IF_ID_Flush = 1'b0;
        ID_EX_Flush = 1'b0;
        if (Branch_Taken) begin
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
        end else if (md_stall || ld_stall) begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
        end
    end

`ifdef STALL_STATS_EN
    logic ld_win;
    logic md_win;

    assign md_win = !Branch_Taken && md_stall;
    assign ld_win = !Branch_Taken && !md_stall && ld_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            Stat_LdStall <= '0;
            Stat_MdStall <= '0;
            Stat_Flush   <= '0;
        end else begin
            if (ld_win && (Stat_LdStall != '1)) Stat_LdStall <= Stat_LdStall + 32'd1;
            if (md_win && (Stat_MdStall != '1)) Stat_MdStall <= Stat_MdStall + 32'd1;
            if (Branch_Taken && (Stat_Flush != '1)) Stat_Flush <= Stat_Flush + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: directed per-cycle vectors push expected outputs,
// a negedge monitor pops and compares.
module tb_pipeline_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ID_EX_MemRead = 1'b0;
    logic [4:0] ID_EX_Rt = '0;
    logic [4:0] IF_ID_Rs = '0;
    logic [4:0] IF_ID_Rt = '0;
    logic       ID_MdUse = 1'b0;
    logic       EX_MdStart = 1'b0;
    logic       EX_MdIsDiv = 1'b0;
    logic       Branch_Taken = 1'b0;
    logic       PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Md_Busy, Md_Done;
`ifdef STALL_STATS_EN
    logic [31:0] Stat_LdStall, Stat_MdStall, Stat_Flush;
`endif

    always #5 clk = ~clk;

    pipeline_stall_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .ID_EX_MemRead(ID_EX_MemRead),
        .ID_EX_Rt     (ID_EX_Rt),
        .IF_ID_Rs     (IF_ID_Rs),
        .IF_ID_Rt     (IF_ID_Rt),
        .ID_MdUse     (ID_MdUse),
        .EX_MdStart   (EX_MdStart),
        .EX_MdIsDiv   (EX_MdIsDiv),
        .Branch_Taken (Branch_Taken),
        .PCWrite      (PCWrite),
        .IF_ID_Write  (IF_ID_Write),
        .IF_ID_Flush  (IF_ID_Flush),
        .ID_EX_Flush  (ID_EX_Flush),
        .Md_Busy      (Md_Busy),
        .Md_Done      (Md_Done)
`ifdef STALL_STATS_EN
        ,
        .Stat_LdStall (Stat_LdStall),
        .Stat_MdStall (Stat_MdStall),
        .Stat_Flush   (Stat_Flush)
`endif
    );

    // Expected vector order: {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Md_Busy, Md_Done}
    localparam logic [5:0] N_IDLE = 6'b110000;
    localparam logic [5:0] N_BUSY = 6'b110010;
    localparam logic [5:0] N_DONE = 6'b110011;
    localparam logic [5:0] S_IDLE = 6'b000100;
    localparam logic [5:0] S_BUSY = 6'b000110;
    localparam logic [5:0] S_DONE = 6'b000111;
    localparam logic [5:0] F_IDLE = 6'b111100;
    localparam logic [5:0] F_BUSY = 6'b111110;

    typedef struct {
        string      nm;
        logic [5:0] v;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Monitor: one expected entry per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [5:0] act;
            e   = q.pop_front();
            act = {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Md_Busy, Md_Done};
            checks++;
            if (act !== e.v) begin
                errors++;
                $display("FAIL %s: got %b expected %b", e.nm, act, e.v);
            end
        end
    end

    task automatic step(input string nm, input logic r, input logic mr, input logic [4:0] ert,
                        input logic [4:0] rs, input logic [4:0] rt, input logic use_md,
                        input logic st, input logic dv, input logic br, input logic [5:0] ev);
        exp_t e;
        @(posedge clk);
        #1;
        rst           = r;
        ID_EX_MemRead = mr;
        ID_EX_Rt      = ert;
        IF_ID_Rs      = rs;
        IF_ID_Rt      = rt;
        ID_MdUse      = use_md;
        EX_MdStart    = st;
        EX_MdIsDiv    = dv;
        Branch_Taken  = br;
        e.nm = nm;
        e.v  = ev;
        q.push_back(e);
    endtask

    task automatic idle(input string nm, input logic use_md, input logic [5:0] ev);
        step(nm, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, use_md, 1'b0, 1'b0, 1'b0, ev);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        step("reset", 1'b1, 0, 0, 0, 0, 0, 0, 0, 0, N_IDLE);
`ifdef STALL_STATS_EN
        @(negedge clk);
        checks++;
        if ({Stat_LdStall, Stat_MdStall, Stat_Flush} !== 96'd0) begin
            errors++;
            $display("FAIL stats_reset: got %h %h %h expected 0", Stat_LdStall, Stat_MdStall,
                     Stat_Flush);
        end
`endif
        // Load-use hazards
        step("lu_rs",     0, 1, 5'd8, 5'd8, 5'd3,  0, 0, 0, 0, S_IDLE);
        step("lu_rt",     0, 1, 5'd9, 5'd1, 5'd9,  0, 0, 0, 0, S_IDLE);
        step("lu_r0",     0, 1, 5'd0, 5'd0, 5'd0,  0, 0, 0, 0, N_IDLE);
        step("lu_noload", 0, 0, 5'd8, 5'd8, 5'd8,  0, 0, 0, 0, N_IDLE);
        step("lu_nomatch",0, 1, 5'd8, 5'd9, 5'd10, 0, 0, 0, 0, N_IDLE);
        step("br_over_lu",0, 1, 5'd8, 5'd8, 5'd0,  0, 0, 0, 1, F_IDLE);

        // MULT, dependent instruction held in ID; a stray start in RUN is ignored
        step("mul_c0", 0, 0, 0, 0, 0, 1, 1, 0, 0, N_IDLE);
        idle("mul_c1", 1'b1, S_BUSY);
        step("mul_c2_badstart", 0, 1, 5'd4, 5'd4, 5'd0, 1, 1, 1, 0, S_BUSY);
        idle("mul_c3", 1'b1, S_DONE);
        idle("mul_c4", 1'b1, N_IDLE);

        // DIV with independent instructions: never stalls
        step("div_c0", 0, 0, 0, 0, 0, 0, 1, 1, 0, N_IDLE);
        for (int i = 1; i <= 30; i++) idle($sformatf("div_c%0d", i), 1'b0, N_BUSY);
        idle("div_c31", 1'b0, N_DONE);
        idle("div_c32", 1'b0, N_IDLE);

        // Branch during a dependent stall; the divide still finishes on schedule
        step("bdiv_c0", 0, 0, 0, 0, 0, 0, 1, 1, 0, N_IDLE);
        for (int i = 1; i <= 4; i++) idle($sformatf("bdiv_c%0d", i), 1'b1, S_BUSY);
        step("bdiv_c5_br", 0, 0, 0, 0, 0, 1, 0, 0, 1, F_BUSY);
        for (int i = 6; i <= 30; i++) idle($sformatf("bdiv_c%0d", i), 1'b0, N_BUSY);
        idle("bdiv_c31", 1'b0, N_DONE);
        idle("bdiv_c32", 1'b0, N_IDLE);

        // Back-to-back MULTs
        step("b2b_c0", 0, 0, 0, 0, 0, 0, 1, 0, 0, N_IDLE);
        idle("b2b_c1", 1'b0, N_BUSY);
        idle("b2b_c2", 1'b0, N_BUSY);
        step("b2b_c3", 0, 0, 0, 0, 0, 0, 1, 0, 0, N_DONE);
        idle("b2b_c4", 1'b0, N_BUSY);
        idle("b2b_c5", 1'b0, N_BUSY);
        idle("b2b_c6", 1'b0, N_DONE);
        idle("b2b_c7", 1'b0, N_IDLE);

        // Reset mid-operation abandons it
        step("rst_c0", 0, 0, 0, 0, 0, 0, 1, 0, 0, N_IDLE);
        idle("rst_c1", 1'b0, N_BUSY);
        step("rst_c2", 1, 0, 0, 0, 0, 0, 0, 0, 0, N_BUSY);
        idle("rst_c3", 1'b0, N_IDLE);
        idle("rst_c4", 1'b0, N_IDLE);
        idle("rst_c5", 1'b0, N_IDLE);
`ifdef STALL_STATS_EN
        @(negedge clk);
        checks++;
        if ({Stat_LdStall, Stat_MdStall, Stat_Flush} !== 96'd0) begin
            errors++;
            $display("FAIL stats_after_rst: got %h %h %h expected 0", Stat_LdStall,
                     Stat_MdStall, Stat_Flush);
        end
`endif

        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline.
- Sequences the iterative MULT/DIV unit: counts its latency, signals HI/LO write-back, and holds IF/ID while a dependent instruction waits.
- Merges three stall/flush sources into one set of pipeline control signals, in priority order: taken-branch flush, mult/div busy stall, load-use stall.
- Sits in ID, beside the register file.

Parameters:
- MUL_CYCLES, 4, EX cycles a MULT/MULTU occupies, counted from the start cycle (min 2).
- DIV_CYCLES, 32, EX cycles a DIV/DIVU occupies (min 2, max 2^CNT_W).
- CNT_W, 6, latency counter width.

Ports:
- clk  input  1  pipeline clock
- rst  input  1  synchronous active-high reset
- ID_EX_MemRead  input  1  instruction in EX is a load
- ID_EX_Rt  input  5  load destination register in EX
- IF_ID_Rs  input  5  source register 1 of the instruction in ID
- IF_ID_Rt  input  5  source register 2 of the instruction in ID
- ID_MdUse  input  1  instruction in ID is MFHI/MFLO/MTHI/MTLO/MULT/DIV
- EX_MdStart  input  1  mult/div instruction entering EX this cycle
- EX_MdIsDiv  input  1  qualifies EX_MdStart: 1 = divide, 0 = multiply
- Branch_Taken  input  1  branch/jump resolved taken in EX
- PCWrite  output  1  PC update enable
- IF_ID_Write  output  1  IF/ID register write enable
- IF_ID_Flush  output  1  zero the IF/ID register
- ID_EX_Flush  output  1  insert a bubble into ID/EX
- Md_Busy  output  1  mult/div unit occupied
- Md_Done  output  1  one-cycle pulse; HI/LO written at the end of this cycle

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset: state=IDLE, counter=0.
- During reset and after it: Md_Busy=0, Md_Done=0, PCWrite=1, IF_ID_Write=1, IF_ID_Flush=0, ID_EX_Flush=0.
- Reset asserted mid-operation abandons the operation: no Md_Done pulse is produced.
- State machine, registered:
  - IDLE: on EX_MdStart, load counter=(EX_MdIsDiv ? DIV_CYCLES : MUL_CYCLES)-2 and go to RUN.
  - RUN: decrement counter each cycle; when counter==0, go to DONE.
  - DONE: go to IDLE. If EX_MdStart is asserted in DONE, reload the counter and go straight to RUN (back-to-back operations).
- EX_MdStart in RUN is a protocol violation: ignored, no state change. The stall logic prevents it from occurring.
- Md_Busy = (state != IDLE).
- Md_Done = (state == DONE).
- Total occupancy: the start cycle in IDLE, then LATENCY-1 cycles in RUN/DONE.
- Pipeline controls are combinational from state and inputs, priority high to low:
  1. Branch_Taken: PCWrite=1, IF_ID_Write=1, IF_ID_Flush=1, ID_EX_Flush=1. Both wrong-path instructions are killed, and any pending stall is dropped with them.
  2. Md stall, when Md_Busy && ID_MdUse: PCWrite=0, IF_ID_Write=0, IF_ID_Flush=0, ID_EX_Flush=1. The stall includes the DONE cycle; the dependent instruction proceeds in the first IDLE cycle.
  3. Load-use stall, when ID_EX_MemRead && ID_EX_Rt!=0 && (ID_EX_Rt==IF_ID_Rs || ID_EX_Rt==IF_ID_Rt): same outputs as the Md stall. Register 0 never stalls.
  4. Otherwise: PCWrite=1, IF_ID_Write=1, both flushes 0.
- Branch_Taken does not cancel a running mult/div; the counter keeps running.
- Md stall and load-use stall together: one combined stall. The stall repeats each cycle until both conditions clear.

Optional Feature:
- Macro: STALL_STATS_EN.
- When defined, three extra outputs, each a 32-bit registered counter:
  - Stat_LdStall: counts cycles where the load-use stall is the winning source.
  - Stat_MdStall: counts cycles where the Md stall wins.
  - Stat_Flush: counts cycles with Branch_Taken.
- Counters are saturating at 32'hFFFFFFFF and clear on rst.
- When not defined: the ports and logic are absent; core behaviour is identical.

Test Plan:
- Load-use: ID_EX_MemRead=1, ID_EX_Rt=8, IF_ID_Rs=8 -> PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1 that cycle. Same with ID_EX_Rt=0, IF_ID_Rs=0 -> no stall.
- MULT with MUL_CYCLES=4: EX_MdStart=1, EX_MdIsDiv=0 at cycle 0 -> Md_Busy=1 in cycles 1-3, Md_Done=1 in cycle 3 only, Md_Busy=0 in cycle 4. ID_MdUse=1 held throughout -> stalled in cycles 1-3, released in cycle 4.
- DIV with DIV_CYCLES=32 -> Md_Done exactly at cycle 31 after start. Independent instructions (ID_MdUse=0) never stall during the divide.
- Branch_Taken=1 while Md_Busy && ID_MdUse -> IF_ID_Flush=1, ID_EX_Flush=1, PCWrite=1. Divide still completes, Md_Done at its scheduled cycle.
- Back-to-back: EX_MdStart during DONE -> Md_Busy stays 1 with no IDLE gap, second Md_Done after a further LATENCY-1 cycles.
- rst asserted in RUN -> next cycle Md_Busy=0, no Md_Done pulse. With STALL_STATS_EN, all Stat_* counters read 0.
